logic_ops_pipe: RTL and testbench
=================================

LOGIC_OPS_PIPE -- requirements
Module: logic_ops_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 1..64).
REQ-002 Parameter CNT_W, default 8, width of the completed-transaction counter.
REQ-003 Port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port a, input, WIDTH bits, operand A.
REQ-006 Port b, input, WIDTH bits, operand B.
REQ-007 Port in_valid, input, 1 bit, high when a/b carry an operand pair.
REQ-008 Port in_ready, output, 1 bit, block can accept an operand pair this cycle.
REQ-009 Port out, output, 6*WIDTH bits, packed results: slice k = out[k*WIDTH +: WIDTH], k=0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR.
REQ-010 Port out_valid, output, 1 bit, out holds a valid result.
REQ-011 Port out_ready, input, 1 bit, consumer accepts out this cycle.
REQ-012 Port txn_cnt, output, CNT_W bits, number of completed output handshakes, modulo 2^CNT_W.

Function
REQ-013 Input handshake SHALL occur on a rising edge where in_valid and in_ready are both high; output handshake where out_valid and out_ready are both high.
REQ-014 Stage 1 SHALL register a, b and a valid bit (s1_valid) on each input handshake.
REQ-015 Stage 2 SHALL register the six bitwise results of the stage-1 operands, plus a valid bit (s2_valid) driving out_valid.
REQ-016 s2_adv SHALL be defined as (~s2_valid | out_ready).
REQ-017 Stage 2 SHALL load when s2_adv is high.
REQ-018 When stage 2 loads, s2_valid SHALL take s1_valid.
REQ-019 in_ready SHALL equal (~s1_valid | s2_adv), combinationally, with no combinational path from in_valid.
REQ-020 Stage 1 SHALL load when in_ready is high.
REQ-021 When stage 1 loads, s1_valid SHALL take in_valid; operand registers capture only on handshake.
REQ-022 Latency: with out_ready held high, a pair accepted at edge N SHALL appear on out with out_valid high after edge N+2.
REQ-023 Throughput: with out_ready held high and in_valid continuous, one result per cycle; no bubbles inserted.
REQ-024 While out_valid is high and out_ready is low, out and out_valid SHALL hold stable.
REQ-025 When out_ready is low and both stages are full, in_ready SHALL be low.
REQ-026 No transaction SHALL be dropped, duplicated or reordered under any out_ready pattern.
REQ-027 Each result slice SHALL be exactly WIDTH bits, bitwise per position, with no carry or sign interaction between bits.
REQ-028 txn_cnt SHALL increment by 1 on each output handshake.
REQ-029 txn_cnt SHALL wrap from 2^CNT_W-1 to 0.
REQ-030 Simultaneous input and output handshakes in one cycle SHALL both take effect: pipeline advances and new pair enters stage 1.

Reset
REQ-031 While rst_n is low, s1_valid, s2_valid, out_valid, out, txn_cnt and all operand registers SHALL be 0.
REQ-032 While rst_n is low, in_ready SHALL be 1, since stage 1 is empty.
REQ-033 Reset assertion mid-operation SHALL discard all in-flight pairs immediately and asynchronously.
REQ-034 After release, the first input handshake SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-035 WIDTH=8, a=8'h0F, b=8'h33, out_ready=1 -> two edges later out slices AND 03, OR 3F, XOR 3C, NAND FC, NOR C0, XNOR C3; txn_cnt=1.
REQ-036 WIDTH=1 sequence (a,b)=(0,1),(1,0),(1,1) back-to-back -> out = 6'b001110, 6'b001110, 6'b100011 on consecutive cycles; txn_cnt=3.
REQ-037 Four pairs sent, out_ready low for 5 cycles then high -> in_ready low after 2 accepts, first result held stable, all 4 results emerge in order, txn_cnt=4.
REQ-038 CNT_W=2, 5 transactions -> txn_cnt sequence 1,2,3,0,1.
REQ-039 rst_n pulsed low with 2 pairs in flight -> out_valid=0, txn_cnt=0, in_ready=1 during reset; no stale result after release.
REQ-040 Random in_valid/out_ready for 1000 cycles, WIDTH=13 -> scoreboard matches every result in order, no loss or duplication.

Source files
------------

// File: rtl/logic_ops_pipe.sv
// Two-stage valid/ready pipeline producing six bitwise results (AND, OR, XOR, NAND, NOR, XNOR)
// of two operands, with a wrapping counter of completed output handshakes.
module logic_ops_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [6*WIDTH-1:0]   out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     txn_cnt
);

  localparam int unsigned OUT_W = 6 * WIDTH;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               s2_adv_c;
  logic               in_ready_c;

  // Stage enables and next-state; stage 1 may refill in the same cycle stage 2 drains.
  always_comb begin
    s2_adv_c   = ~s2_valid_q | out_ready;
    in_ready_c = ~s1_valid_q | s2_adv_c;

    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    cnt_d      = cnt_q;

    if (in_ready_c) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d = a;
        b_d = b;
      end
    end

    if (s2_adv_c) begin
      s2_valid_d = s1_valid_q;
      res_d      = {~(a_q ^ b_q), ~(a_q | b_q), ~(a_q & b_q), a_q ^ b_q, a_q | b_q, a_q & b_q};
    end

    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out       = res_q;
  assign out_valid = s2_valid_q;
  assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_ops_pipe.sv
// Self-checking bench for logic_ops_pipe: directed vectors (WIDTH=8), a 1-bit instance with a
// 2-bit counter, and a randomized 13-bit instance scored against a truth-table/queue model.
module tb_logic_ops_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8;
  logic        iv8, ir8, ov8, or8;
  logic [47:0] out8;
  logic [7:0]  cnt8;

  logic        a1, b1, iv1, ir1, ov1, or1;
  logic [5:0]  out1;
  logic [1:0]  cnt1;

  logic [12:0] a13, b13;
  logic        iv13, ir13, ov13, or13;
  logic [77:0] out13;
  logic [7:0]  cnt13;

  logic_ops_pipe #(.WIDTH(8), .CNT_W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8), .in_ready(ir8),
    .out(out8), .out_valid(ov8), .out_ready(or8), .txn_cnt(cnt8));

  logic_ops_pipe #(.WIDTH(1), .CNT_W(2)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .in_ready(ir1),
    .out(out1), .out_valid(ov1), .out_ready(or1), .txn_cnt(cnt1));

  logic_ops_pipe #(.WIDTH(13), .CNT_W(8)) u_w13 (
    .clk(clk), .rst_n(rst_n), .a(a13), .b(b13), .in_valid(iv13), .in_ready(ir13),
    .out(out13), .out_valid(ov13), .out_ready(or13), .txn_cnt(cnt13));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result of all six operations built bit by bit from each operation's truth table.
  function automatic logic [77:0] model(input int unsigned w, input logic [12:0] x,
                                        input logic [12:0] y);
    logic [3:0]  tt[6];
    logic [77:0] r;
    logic [1:0]  sel;
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};
    r  = '0;
    for (int k = 0; k < 6; k++) begin
      for (int unsigned i = 0; i < w; i++) begin
        sel = {x[i], y[i]};
        r[k*w+i] = tt[k][sel];
      end
    end
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    iv8 = 1'b0; iv1 = 1'b0; iv13 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(ir8), 128'(1'b1));
    chk("rst_out_valid", 128'(ov8), 128'(1'b0));
    chk("rst_out", 128'(out8), 128'(0));
    chk("rst_txn_cnt", 128'(cnt8), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  logic [7:0]  pa[4], pb[4];
  logic        ba[5], bb[5];
  logic [5:0]  exp_b[5];
  logic [1:0]  exp_cnt_b[6];
  logic [25:0] q[$];
  logic [25:0] p;
  int          idx, got, nhs;
  logic        prev_ov, prev_or;
  logic [77:0] prev_out;

  initial begin
    rst_n = 1'b0;
    a8 = '0; b8 = '0; iv8 = 1'b0; or8 = 1'b1;
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    a13 = '0; b13 = '0; iv13 = 1'b0; or13 = 1'b1;

    vecs[0] = '{8'h0F, 8'h33, {8'hC3, 8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03}};
    vecs[1] = '{8'hFF, 8'h00, {8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00}};
    vecs[2] = '{8'hAA, 8'hAA, {8'hFF, 8'h55, 8'h55, 8'h00, 8'hAA, 8'hAA}};
    vecs[3] = '{8'h00, 8'h00, {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}};
    vecs[4] = '{8'h81, 8'hC3, {8'hBD, 8'h3C, 8'h7E, 8'h42, 8'hC3, 8'h81}};
    vecs[5] = '{8'hFF, 8'hFF, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF}};

    pa = '{8'h12, 8'hA5, 8'hFF, 8'h3C};
    pb = '{8'h34, 8'h5A, 8'h0F, 8'hC3};

    ba = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_b = '{6'b001110, 6'b001110, 6'b100011, 6'b111000, 6'b001110};
    exp_cnt_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    do_reset();

    // Directed vectors, one transaction at a time, out_ready high.
    for (int i = 0; i < 6; i++) begin
      a8 = vecs[i].a; b8 = vecs[i].b; iv8 = 1'b1; or8 = 1'b1;
      tick();
      iv8 = 1'b0;
      tick();
      chk("vec_out_valid", 128'(ov8), 128'(1'b1));
      chk("vec_out", 128'(out8), 128'(vecs[i].exp));
      tick();
      chk("vec_txn_cnt", 128'(cnt8), 128'(i + 1));
      chk("vec_drained", 128'(ov8), 128'(1'b0));
    end

    // Stall: four pairs offered while the consumer holds off for five cycles.
    do_reset();
    or8 = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      iv8 = (idx < 4);
      a8 = pa[idx[1:0]]; b8 = pb[idx[1:0]];
      #1;
      chk("stall_in_ready", 128'(ir8), 128'(c < 2));
      if (c >= 2) begin
        chk("stall_hold_valid", 128'(ov8), 128'(1'b1));
        chk("stall_hold_out", 128'(out8), 128'(model(8, 13'(pa[0]), 13'(pb[0]))));
      end
      if (iv8 && ir8) idx++;
      tick();
    end
    or8 = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      iv8 = (idx < 4);
      a8 = pa[idx[1:0]]; b8 = pb[idx[1:0]];
      #1;
      if (ov8) begin
        chk("stall_order", 128'(out8), 128'(model(8, 13'(pa[got[1:0]]), 13'(pb[got[1:0]]))));
        got++;
      end
      if (iv8 && ir8) idx++;
      tick();
    end
    iv8 = 1'b0;
    chk("stall_all_out", 128'(got), 128'(4));
    chk("stall_txn_cnt", 128'(cnt8), 128'(4));

    // Reset asserted asynchronously with two pairs in flight.
    or8 = 1'b0;
    a8 = 8'h5A; b8 = 8'h0F; iv8 = 1'b1;
    tick();
    a8 = 8'h77; b8 = 8'h11;
    tick();
    iv8 = 1'b0;
    chk("inflight_valid", 128'(ov8), 128'(1'b1));
    chk("inflight_blocked", 128'(ir8), 128'(1'b0));
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(ov8), 128'(1'b0));
    chk("async_rst_cnt", 128'(cnt8), 128'(0));
    chk("async_rst_ready", 128'(ir8), 128'(1'b1));
    chk("async_rst_out", 128'(out8), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    or8 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("no_stale_result", 128'(ov8), 128'(1'b0));
    end

    // WIDTH=1, CNT_W=2: back-to-back stream and counter wrap.
    a1 = ba[0]; b1 = bb[0]; iv1 = 1'b1; or1 = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 5) begin
        a1 = ba[e]; b1 = bb[e];
      end else begin
        iv1 = 1'b0;
      end
      #1;
      if (e >= 2) begin
        if (e <= 6) begin
          chk("w1_valid", 128'(ov1), 128'(1'b1));
          chk("w1_out", 128'(out1), 128'(exp_b[e-2]));
        end else begin
          chk("w1_drained", 128'(ov1), 128'(1'b0));
        end
        chk("w1_txn_cnt", 128'(cnt1), 128'(exp_cnt_b[e-2]));
      end
    end

    // Randomized traffic on WIDTH=13 against a queue scoreboard.
    q.delete();
    nhs = 0;
    prev_ov = 1'b0; prev_or = 1'b1; prev_out = '0;
    tick();
    for (int c = 0; c < 1010; c++) begin
      if (c < 1000) begin
        iv13 = ($urandom_range(0, 9) < 7);
        a13  = 13'($urandom);
        b13  = 13'($urandom);
        or13 = ($urandom_range(0, 9) < 6);
      end else begin
        iv13 = 1'b0;
        or13 = 1'b1;
      end
      #1;
      if (prev_ov && !prev_or) begin
        chk("rand_hold", 128'({ov13, out13}), 128'({1'b1, prev_out}));
      end
      if (ov13 && or13) begin
        nhs++;
        if (q.size() == 0) begin
          chk("rand_unexpected", 128'(ov13), 128'(1'b0));
        end else begin
          p = q.pop_front();
          chk("rand_out", 128'(out13), 128'(model(13, p[25:13], p[12:0])));
        end
      end
      if (iv13 && ir13) q.push_back({a13, b13});
      prev_ov = ov13; prev_or = or13; prev_out = out13;
      tick();
    end
    chk("rand_drained", 128'(q.size()), 128'(0));
    chk("rand_txn_cnt", 128'(cnt13), 128'(8'(nhs)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
